ppu_oam_dma: RTL and testbench

- Controller and arbiter for the PPU primary OAM write path.
- Decodes CPU writes to OAMADDR ($2003), OAMDATA ($2004) and OAMDMA ($4014).
- Sequences the 256-byte page copy from CPU address space into OAM, halting the CPU for the duration.
- Shares the single OAM port with the sprite renderer, which always wins while rendering is active.

---
 rtl/ppu_oam_dma_if.sv | 47 ++++
 rtl/ppu_oam_dma.sv | 176 +++++++++++++++++
 tb/tb_ppu_oam_dma.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_oam_dma_if.sv
//==============================================================================
// Module      : ppu_oam_dma_if
// Description : Groups the CPU register port, the DMA read port on the CPU bus
//               and the shared OAM write port used by ppu_oam_dma.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ppu_oam_dma_if;
   // CPU register write port
   logic        cpu_ce;
   logic        reg_we;
   logic [15:0] reg_addr;
   logic [7:0]  reg_wdata;
   logic        cpu_rdy;
   logic        dma_busy;

   // DMA read port on the CPU bus
   logic [15:0] bus_addr;
   logic        bus_rd;
   logic [7:0]  bus_rdata;

   // Shared OAM port
   logic        render_active;
   logic [7:0]  ren_oam_addr;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;
   logic        oam_we;
   logic [7:0]  oamaddr_q;

   modport slave (
      input  cpu_ce, reg_we, reg_addr, reg_wdata,
      input  bus_rdata, render_active, ren_oam_addr,
      output cpu_rdy, dma_busy, bus_addr, bus_rd,
      output oam_addr, oam_wdata, oam_we, oamaddr_q
   );

   modport master (
      output cpu_ce, reg_we, reg_addr, reg_wdata,
      output bus_rdata, render_active, ren_oam_addr,
      input  cpu_rdy, dma_busy, bus_addr, bus_rd,
      input  oam_addr, oam_wdata, oam_we, oamaddr_q
   );
endinterface

`default_nettype wire

// File: rtl/ppu_oam_dma.sv
//==============================================================================
// Module      : ppu_oam_dma
// Description : PPU primary-OAM write controller: OAMADDR/OAMDATA decode,
//               256-byte OAMDMA page copy with CPU halt, renderer arbitration.
//               Define PPU_OAM_DMA_ALIGN_EN to insert the odd-cycle ALIGN state.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ppu_oam_dma #(
   parameter logic [15:0] DMA_REG     = 16'h4014,
   parameter logic [15:0] OAMADDR_REG = 16'h2003,
   parameter logic [15:0] OAMDATA_REG = 16'h2004
) (
   input  wire          clk,
   input  wire          reset_n,
   ppu_oam_dma_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_READ  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_page;
   logic [7:0] w_page_nxt;
   logic [7:0] r_count;
   logic [7:0] w_count_nxt;
   logic [7:0] r_oamaddr;
   logic [7:0] w_oamaddr_nxt;
   logic [7:0] r_oam_addr;
   logic [7:0] w_oam_addr_nxt;
   logic [7:0] r_oam_wdata;
   logic [7:0] w_oam_wdata_nxt;
   logic       r_oam_we;
   logic       w_oam_we_nxt;
   logic       r_held;
   logic       w_held_nxt;
   logic       w_reg_wr;
   logic       w_align_req;
   logic       w_dma_phase;
   logic [7:0] w_dma_byte;

`ifdef PPU_OAM_DMA_ALIGN_EN
   logic r_parity;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_parity <= 1'b0;
      end else if (bus.cpu_ce) begin
         r_parity <= ~r_parity;
      end
   end

   // Parity sampled before this cpu_ce's toggle = parity of the HALT cycle itself
   assign w_align_req = r_parity;
`else
   assign w_align_req = 1'b0;
`endif

   assign w_reg_wr    = bus.cpu_ce & bus.reg_we;
   assign w_dma_phase = (r_state == S_HALT) || (r_state == S_ALIGN) ||
                        (r_state == S_READ) || (r_state == S_WRITE);
   // A byte stalled by the renderer is replayed from the held copy
   assign w_dma_byte  = r_held ? r_oam_wdata : bus.bus_rdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_page      <= 8'd0;
         r_count     <= 8'd0;
         r_oamaddr   <= 8'd0;
         r_oam_addr  <= 8'd0;
         r_oam_wdata <= 8'd0;
         r_oam_we    <= 1'b0;
         r_held      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_page      <= w_page_nxt;
         r_count     <= w_count_nxt;
         r_oamaddr   <= w_oamaddr_nxt;
         r_oam_addr  <= w_oam_addr_nxt;
         r_oam_wdata <= w_oam_wdata_nxt;
         r_oam_we    <= w_oam_we_nxt;
         r_held      <= w_held_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_page_nxt      = r_page;
      w_count_nxt     = r_count;
      w_oamaddr_nxt   = r_oamaddr;
      w_oam_addr_nxt  = r_oam_addr;
      w_oam_wdata_nxt = r_oam_wdata;
      w_oam_we_nxt    = 1'b0;
      w_held_nxt      = r_held;

      case (r_state)
         S_IDLE: begin
            if (w_reg_wr) begin
               if (bus.reg_addr == OAMADDR_REG) begin
                  w_oamaddr_nxt = bus.reg_wdata;
               end else if (bus.reg_addr == OAMDATA_REG) begin
                  if (!bus.render_active) begin
                     w_oam_we_nxt    = 1'b1;
                     w_oam_addr_nxt  = r_oamaddr;
                     w_oam_wdata_nxt = bus.reg_wdata;
                     w_oamaddr_nxt   = r_oamaddr + 8'd1;
                  end
               end else if (bus.reg_addr == DMA_REG) begin
                  w_page_nxt  = bus.reg_wdata;
                  w_count_nxt = 8'd0;
                  w_held_nxt  = 1'b0;
                  w_state_nxt = S_HALT;
               end
            end
         end
         S_HALT: begin
            if (bus.cpu_ce) begin
               w_state_nxt = w_align_req ? S_ALIGN : S_READ;
            end
         end
         S_ALIGN: begin
            if (bus.cpu_ce) begin
               w_state_nxt = S_READ;
            end
         end
         S_READ: begin
            if (bus.cpu_ce) begin
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            if (bus.cpu_ce) begin
               w_oam_wdata_nxt = w_dma_byte;
               if (bus.render_active) begin
                  w_held_nxt = 1'b1;
               end else begin
                  w_oam_we_nxt   = 1'b1;
                  w_oam_addr_nxt = r_oamaddr + r_count;
                  w_count_nxt    = r_count + 8'd1;
                  w_held_nxt     = 1'b0;
                  w_state_nxt    = (r_count == 8'hFF) ? S_DONE : S_READ;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.cpu_rdy   = ~w_dma_phase;
   assign bus.dma_busy  = w_dma_phase;
   assign bus.bus_addr  = {r_page, r_count};
   assign bus.bus_rd    = (r_state == S_READ);
   // Renderer owns the OAM port outright while active
   assign bus.oam_addr  = bus.render_active ? bus.ren_oam_addr : r_oam_addr;
   assign bus.oam_we    = r_oam_we & ~bus.render_active;
   assign bus.oam_wdata = r_oam_wdata;
   assign bus.oamaddr_q = r_oamaddr;

endmodule

`default_nettype wire

// File: tb/tb_ppu_oam_dma.sv
//==============================================================================
// Module      : tb_ppu_oam_dma
// Description : Directed self-checking bench for ppu_oam_dma.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ppu_oam_dma;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   ppu_oam_dma_if dut_if();

   ppu_oam_dma dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (dut_if)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  oam [256];
   logic [15:0] rd_log [4096];
   int ce_idx   = 0;
   int low_cnt  = 0;
   int we_cnt   = 0;
   int rd_cnt   = 0;
   int viol_cnt = 0;

   int          lat, nrd, nwe, exp_lat;
   logic [15:0] first_a, last_a;

   function automatic logic [7:0] mem_val(input logic [15:0] a);
      if (a[15:8] == 8'h02) return a[7:0] ^ 8'h5A;
      return a[7:0] ^ 8'hC3;
   endfunction

   // CPU-bus memory model and cycle index since reset
   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ce_idx            <= 0;
         dut_if.bus_rdata  <= 8'd0;
      end else begin
         if (dut_if.cpu_ce) ce_idx <= ce_idx + 1;
         if (dut_if.cpu_ce && dut_if.bus_rd) dut_if.bus_rdata <= mem_val(dut_if.bus_addr);
      end
   end

   // OAM model and event counters
   always @(negedge clk) begin
      if (dut_if.cpu_ce && !dut_if.cpu_rdy) low_cnt <= low_cnt + 1;
      if (dut_if.oam_we) begin
         oam[dut_if.oam_addr] <= dut_if.oam_wdata;
         we_cnt <= we_cnt + 1;
      end
      if (dut_if.render_active && dut_if.oam_we) viol_cnt <= viol_cnt + 1;
      if (dut_if.cpu_ce && dut_if.bus_rd) begin
         rd_log[rd_cnt % 4096] <= dut_if.bus_addr;
         rd_cnt <= rd_cnt + 1;
      end
   end

   // One CPU cycle = 3 clks, cpu_ce on the first
   task automatic cpu_cycle(input logic we, input logic [15:0] a, input logic [7:0] d);
      dut_if.cpu_ce    = 1'b1;
      dut_if.reg_we    = we;
      dut_if.reg_addr  = a;
      dut_if.reg_wdata = d;
      @(posedge clk); #1;
      dut_if.cpu_ce = 1'b0;
      dut_if.reg_we = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic do_dma(input logic [7:0] page, input int stall_byte, input bit mid_wr);
      int  low0, rd0, we0, left;
      bit  done, armed, fired;
`ifdef PPU_OAM_DMA_ALIGN_EN
      int  n;
      n = ce_idx;
      exp_lat = 513 + ((n + 1) % 2);
`else
      exp_lat = 513;
`endif
      if (stall_byte >= 0) exp_lat = exp_lat + 5;
      low0 = low_cnt; rd0 = rd_cnt; we0 = we_cnt;
      done = 1'b0; armed = 1'b0; fired = 1'b0; left = 0;
      cpu_cycle(1'b1, 16'h4014, page);
      checks++;
      if (dut_if.cpu_rdy !== 1'b0 || dut_if.dma_busy !== 1'b1) begin
         errors++;
         $display("FAIL dma_start rdy=%b busy=%b exp rdy=0 busy=1", dut_if.cpu_rdy, dut_if.dma_busy);
      end
      for (int i = 0; i < 1200 && !done; i++) begin
         if (stall_byte >= 0 && !fired && !armed && dut_if.bus_rd &&
             dut_if.bus_addr[7:0] == stall_byte[7:0]) begin
            armed = 1'b1;
         end else if (armed && !dut_if.bus_rd) begin
            armed = 1'b0; fired = 1'b1; left = 5;
            dut_if.render_active = 1'b1;
            dut_if.ren_oam_addr  = 8'h33;
            #1;
            checks++;
            if (dut_if.oam_addr !== 8'h33) begin
               errors++;
               $display("FAIL stall_oam_addr got %h exp 33", dut_if.oam_addr);
            end
         end
         if (mid_wr && i == 100)      cpu_cycle(1'b1, 16'h4014, 8'h03);
         else if (mid_wr && i == 150) cpu_cycle(1'b1, 16'h2003, 8'h99);
         else                         cpu_cycle(1'b0, 16'h0000, 8'h00);
         if (left > 0) begin
            left--;
            if (left == 0) dut_if.render_active = 1'b0;
         end
         if (dut_if.cpu_rdy) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL dma_timeout cpu_rdy=%b exp 1 within budget", dut_if.cpu_rdy);
      end
      lat     = low_cnt - low0;
      nrd     = rd_cnt - rd0;
      nwe     = we_cnt - we0;
      first_a = rd_log[rd0 % 4096];
      last_a  = rd_log[(rd_cnt - 1) % 4096];
   endtask

   task automatic check_dma_common(input string tag, input logic [7:0] base);
      int bad;
      logic [7:0] idx;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         idx = base + i[7:0];
         if (oam[idx] !== (i[7:0] ^ 8'h5A)) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL %s_data bad_bytes=%0d exp 0", tag, bad); end
      checks++;
      if (lat != exp_lat) begin errors++; $display("FAIL %s_latency got %0d exp %0d", tag, lat, exp_lat); end
      checks++;
      if (nrd != 256 || nwe != 256) begin
         errors++; $display("FAIL %s_counts reads=%0d writes=%0d exp 256", tag, nrd, nwe);
      end
      checks++;
      if (first_a !== 16'h0200 || last_a !== 16'h02FF) begin
         errors++; $display("FAIL %s_bus_addr first=%h last=%h exp 0200/02FF", tag, first_a, last_a);
      end
      checks++;
      if (dut_if.oamaddr_q !== base || dut_if.dma_busy !== 1'b0) begin
         errors++; $display("FAIL %s_end oamaddr_q=%h busy=%b exp %h/0", tag, dut_if.oamaddr_q, dut_if.dma_busy, base);
      end
   endtask

   task automatic test_reset;
      checks++;
      if (dut_if.cpu_rdy !== 1'b1 || dut_if.dma_busy !== 1'b0) begin
         errors++; $display("FAIL reset_rdy_busy rdy=%b busy=%b exp 1/0", dut_if.cpu_rdy, dut_if.dma_busy);
      end
      checks++;
      if (dut_if.bus_rd !== 1'b0 || dut_if.oam_we !== 1'b0) begin
         errors++; $display("FAIL reset_strobes bus_rd=%b oam_we=%b exp 0/0", dut_if.bus_rd, dut_if.oam_we);
      end
      checks++;
      if (dut_if.bus_addr !== 16'h0000 || dut_if.oam_addr !== 8'h00) begin
         errors++; $display("FAIL reset_addr bus_addr=%h oam_addr=%h exp 0", dut_if.bus_addr, dut_if.oam_addr);
      end
      checks++;
      if (dut_if.oam_wdata !== 8'h00 || dut_if.oamaddr_q !== 8'h00) begin
         errors++; $display("FAIL reset_data oam_wdata=%h oamaddr_q=%h exp 0", dut_if.oam_wdata, dut_if.oamaddr_q);
      end
   endtask

   task automatic test_reg_write;
      int we0;
      we0 = we_cnt;
      cpu_cycle(1'b1, 16'h2003, 8'h10);
      cpu_cycle(1'b1, 16'h2004, 8'hAB);
      cpu_cycle(1'b1, 16'h2004, 8'hCD);
      checks++;
      if (oam[8'h10] !== 8'hAB || oam[8'h11] !== 8'hCD) begin
         errors++; $display("FAIL oamdata_write oam10=%h oam11=%h exp AB/CD", oam[8'h10], oam[8'h11]);
      end
      checks++;
      if (dut_if.oamaddr_q !== 8'h12) begin
         errors++; $display("FAIL oamaddr_inc got %h exp 12", dut_if.oamaddr_q);
      end
      checks++;
      if (we_cnt - we0 != 2) begin
         errors++; $display("FAIL oamdata_pulses got %0d exp 2", we_cnt - we0);
      end
   endtask

   task automatic test_render_drop;
      int we0;
      we0 = we_cnt;
      dut_if.render_active = 1'b1;
      dut_if.ren_oam_addr  = 8'h77;
      #1;
      checks++;
      if (dut_if.oam_addr !== 8'h77) begin
         errors++; $display("FAIL render_mux got %h exp 77", dut_if.oam_addr);
      end
      cpu_cycle(1'b1, 16'h2004, 8'h55);
      dut_if.ren_oam_addr = 8'h78;
      #1;
      checks++;
      if (dut_if.oam_addr !== 8'h78) begin
         errors++; $display("FAIL render_follow got %h exp 78", dut_if.oam_addr);
      end
      checks++;
      if (we_cnt - we0 != 0 || dut_if.oamaddr_q !== 8'h12) begin
         errors++; $display("FAIL render_drop pulses=%0d oamaddr_q=%h exp 0/12", we_cnt - we0, dut_if.oamaddr_q);
      end
      dut_if.render_active = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_dma_basic;
      cpu_cycle(1'b1, 16'h2003, 8'h00);
      do_dma(8'h02, -1, 1'b0);
      check_dma_common("dma_basic", 8'h00);
   endtask

   task automatic test_dma_wrap;
      cpu_cycle(1'b1, 16'h2003, 8'hF0);
      do_dma(8'h02, -1, 1'b0);
      checks++;
      if (oam[8'hF0] !== 8'h5A || oam[8'h00] !== 8'h4A) begin
         errors++; $display("FAIL wrap_edges oamF0=%h oam00=%h exp 5A/4A", oam[8'hF0], oam[8'h00]);
      end
      check_dma_common("dma_wrap", 8'hF0);
   endtask

   task automatic test_back_to_back;
      int v0;
      v0 = viol_cnt;
      cpu_cycle(1'b1, 16'h2003, 8'h00);
      do_dma(8'h02, 7, 1'b1);
      checks++;
      if (viol_cnt - v0 != 0) begin
         errors++; $display("FAIL stall_we_during_render got %0d exp 0", viol_cnt - v0);
      end
      check_dma_common("dma_stall", 8'h00);
   endtask

   task automatic test_reset_mid_dma;
      bit hit;
      hit = 1'b0;
      cpu_cycle(1'b1, 16'h2003, 8'h20);
      cpu_cycle(1'b1, 16'h4014, 8'h02);
      for (int i = 0; i < 200 && !hit; i++) begin
         if (dut_if.bus_rd && dut_if.bus_addr == 16'h0228) hit = 1'b1;
         else cpu_cycle(1'b0, 16'h0000, 8'h00);
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL reset_mid_reach count40 not reached exp reached"); end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (dut_if.cpu_rdy !== 1'b1 || dut_if.dma_busy !== 1'b0 || dut_if.oam_we !== 1'b0) begin
         errors++; $display("FAIL reset_mid_ctl rdy=%b busy=%b we=%b exp 1/0/0", dut_if.cpu_rdy, dut_if.dma_busy, dut_if.oam_we);
      end
      checks++;
      if (dut_if.oamaddr_q !== 8'h00 || dut_if.bus_rd !== 1'b0) begin
         errors++; $display("FAIL reset_mid_regs oamaddr_q=%h bus_rd=%b exp 00/0", dut_if.oamaddr_q, dut_if.bus_rd);
      end
      #3 reset_n = 1'b1;
      @(posedge clk); #1;
      do_dma(8'h02, -1, 1'b0);
      check_dma_common("dma_restart", 8'h00);
   endtask

   initial begin
      reset_n              = 1'b0;
      dut_if.cpu_ce        = 1'b0;
      dut_if.reg_we        = 1'b0;
      dut_if.reg_addr      = 16'h0000;
      dut_if.reg_wdata     = 8'h00;
      dut_if.render_active = 1'b0;
      dut_if.ren_oam_addr  = 8'h00;
      #1;
      test_reset();
      #20 reset_n = 1'b1;
      @(posedge clk); #1;
      test_reg_write();
      test_render_drop();
      test_dma_basic();
      test_dma_wrap();
      test_back_to_back();
      test_reset_mid_dma();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
